cardinal_nic_fifo_if: RTL and testbench

- Memory-mapped network interface between one Cardinal CPU node and its ring router inside the 4-node CMP.
- CPU side: 2-bit register address, 64-bit data, nicEn/nicWrEn strobes, the same signalling the CPU uses toward the NIC.
- Network side: send/ready handshakes with the router in both directions.
- Contains one DEPTH-entry FIFO per direction, plus status registers polled by software.

---
 rtl/cardinal_nic_fifo_if_pkg.sv | 15 +
 rtl/nic_chan_fifo.sv | 60 ++++++
 rtl/cardinal_nic_fifo_if.sv | 94 +++++++++
 tb/tb_cardinal_nic_fifo_if.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cardinal_nic_fifo_if_pkg.sv
// Shared constants for the Cardinal NIC:
// register map, status field layout and VC bit.
package cardinal_nic_fifo_if_pkg;

  localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
  localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
  localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
  localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

  localparam int STAT_FLAG    = 63;
  localparam int STAT_CNT_MSB = 48;
  localparam int STAT_CNT_LSB = 55;
  localparam int VC_BIT       = 0;

endpackage

// File: rtl/nic_chan_fifo.sv
// Single-direction packet FIFO for the NIC.
// No bypass: a pushed entry appears at head next cycle.
module nic_chan_fifo
  import cardinal_nic_fifo_if_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [0:PW-1] push_data,
  input  logic          pop,
  output logic [0:PW-1] head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  logic [0:PW-1] mem_q [DEPTH];
  logic [0:PW-1] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign head  = mem_q[rd_q];

  always_comb begin
    do_push = push & ~full;
    do_pop  = pop & ~empty;
    mem_d   = mem_q;
    if (do_push) mem_d[wr_q] = push_data;
    // power-of-two depth: pointers wrap naturally
    wr_d  = wr_q + AW'(do_push);
    rd_d  = rd_q + AW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cardinal_nic_fifo_if.sv
// Memory-mapped NIC between a Cardinal CPU and its
// ring router: one FIFO per direction plus status regs.
module cardinal_nic_fifo_if
  import cardinal_nic_fifo_if_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int PW    = 64,
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [0:1]    addr,
  input  logic [0:PW-1] d_in,
  output logic [0:PW-1] d_out,
  input  logic          nicEn,
  input  logic          nicWrEn,
  input  logic          net_si,
  output logic          net_ri,
  input  logic [0:PW-1] net_di,
  output logic          net_so,
  input  logic          net_ro,
  output logic [0:PW-1] net_do,
  input  logic          net_polarity
);

  logic          rd_en, wr_en;
  logic          in_push, in_pop;
  logic [0:PW-1] in_head;
  logic          in_full, in_empty;
  logic [CW-1:0] in_cnt;
  logic          out_push, out_pop;
  logic [0:PW-1] out_head;
  logic          out_full, out_empty;
  logic [CW-1:0] out_cnt;

  nic_chan_fifo #(.DEPTH(DEPTH), .PW(PW)) u_in_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_push),
    .push_data (net_di),
    .pop       (in_pop),
    .head      (in_head),
    .full      (in_full),
    .empty     (in_empty),
    .count     (in_cnt)
  );

  nic_chan_fifo #(.DEPTH(DEPTH), .PW(PW)) u_out_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (out_push),
    .push_data (d_in),
    .pop       (out_pop),
    .head      (out_head),
    .full      (out_full),
    .empty     (out_empty),
    .count     (out_cnt)
  );

  always_comb begin
    rd_en    = nicEn & ~nicWrEn;
    wr_en    = nicEn & nicWrEn;
    net_ri   = reset & ~in_full;
    in_push  = net_si & net_ri;
    in_pop   = rd_en & (addr == ADDR_IN_BUF) & ~in_empty;
    out_push = wr_en & (addr == ADDR_OUT_BUF) & ~out_full;
    net_do   = out_empty ? '0 : out_head;
    // router only takes packets on its current VC phase
    net_so   = ~out_empty & net_ro
             & (out_head[VC_BIT] == net_polarity);
    out_pop  = net_so;
  end

  always_comb begin
    d_out = '0;
    if (rd_en && reset) begin
      unique case (1'b1)
        (addr == ADDR_IN_BUF): begin
          if (!in_empty) d_out = in_head;
        end
        (addr == ADDR_IN_STAT): begin
          d_out[STAT_FLAG] = ~in_empty;
          d_out[STAT_CNT_MSB:STAT_CNT_LSB] = 8'(in_cnt);
        end
        (addr == ADDR_OUT_STAT): begin
          d_out[STAT_FLAG] = out_full;
          d_out[STAT_CNT_MSB:STAT_CNT_LSB] = 8'(out_cnt);
        end
        default: d_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cardinal_nic_fifo_if.sv
// Directed bench for cardinal_nic_fifo_if (DEPTH=2).
// Expected values are hand-computed constants.
module tb_cardinal_nic_fifo_if;

  logic        clk = 1'b0;
  logic        reset;
  logic [0:1]  addr;
  logic [0:63] d_in;
  logic [0:63] d_out;
  logic        nicEn;
  logic        nicWrEn;
  logic        net_si;
  logic        net_ri;
  logic [0:63] net_di;
  logic        net_so;
  logic        net_ro;
  logic [0:63] net_do;
  logic        net_polarity;

  int n_chk  = 0;
  int n_fail = 0;

  cardinal_nic_fifo_if #(.DEPTH(2), .PW(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .d_in         (d_in),
    .d_out        (d_out),
    .nicEn        (nicEn),
    .nicWrEn      (nicWrEn),
    .net_si       (net_si),
    .net_ri       (net_ri),
    .net_di       (net_di),
    .net_so       (net_so),
    .net_ro       (net_ro),
    .net_do       (net_do),
    .net_polarity (net_polarity)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a,
                    input logic [63:0] exp,
                    input string tag);
    nicEn   = 1'b1;
    nicWrEn = 1'b0;
    addr    = a;
    @(negedge clk);
    chk(tag, d_out, exp);
    step();
    nicEn = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a,
                    input logic [63:0] d);
    nicEn   = 1'b1;
    nicWrEn = 1'b1;
    addr    = a;
    d_in    = d;
    step();
    nicEn   = 1'b0;
    nicWrEn = 1'b0;
  endtask

  localparam logic [63:0] I1 = 64'hA5A5_0000_0000_0001;
  localparam logic [63:0] I2 = 64'hA5A5_0000_0000_0002;
  localparam logic [63:0] I3 = 64'hA5A5_0000_0000_0003;
  localparam logic [63:0] I4 = 64'hA5A5_0000_0000_0004;
  localparam logic [63:0] I5 = 64'hA5A5_0000_0000_0005;
  localparam logic [63:0] P1 = 64'h0000_0000_0000_0101;
  localparam logic [63:0] P2 = 64'h0000_0000_0000_0202;
  localparam logic [63:0] P3 = 64'h0000_0000_0000_0303;
  localparam logic [63:0] PC = 64'h0000_0000_0000_00C3;
  localparam logic [63:0] ST_2_FLAG = 64'h0000_0000_0000_0201;
  localparam logic [63:0] ST_1_FLAG = 64'h0000_0000_0000_0101;
  localparam logic [63:0] ST_1      = 64'h0000_0000_0000_0100;

  initial begin
    reset = 1'b0;
    addr = 2'b00;
    d_in = '0;
    nicEn = 1'b0;
    nicWrEn = 1'b0;
    net_si = 1'b0;
    net_di = '0;
    net_ro = 1'b0;
    net_polarity = 1'b0;

    #3;
    chk("rst_ri", 64'(net_ri), 64'd0);
    chk("rst_so", 64'(net_so), 64'd0);
    chk("rst_do", net_do, 64'd0);
    chk("rst_dout", d_out, 64'd0);
    step();
    reset = 1'b1;
    #1;
    chk("post_rst_ri", 64'(net_ri), 64'd1);

    // reset mid-run with two outbound entries
    wr(2'b10, P1);
    wr(2'b10, P2);
    rd(2'b11, ST_2_FLAG, "pre_rst_ostat");
    net_ro = 1'b1;
    net_polarity = 1'b0;
    #1;
    chk("pre_rst_so", 64'(net_so), 64'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_so", 64'(net_so), 64'd0);
    chk("mid_rst_ri", 64'(net_ri), 64'd0);
    chk("mid_rst_do", net_do, 64'd0);
    net_ro = 1'b0;
    step();
    reset = 1'b1;
    #1;
    rd(2'b11, 64'd0, "rel_ostat");
    chk("rel_ri", 64'(net_ri), 64'd1);

    // inbound ordering
    net_si = 1'b1;
    net_di = I1;
    step();
    net_di = I2;
    step();
    net_si = 1'b0;
    rd(2'b01, ST_2_FLAG, "in_stat2");
    rd(2'b00, I1, "in_rd1");
    rd(2'b00, I2, "in_rd2");
    rd(2'b00, 64'd0, "in_rd_empty");
    rd(2'b01, 64'd0, "in_stat0");

    // inbound full back-pressure
    net_si = 1'b1;
    net_di = I3;
    step();
    net_di = I4;
    step();
    @(negedge clk);
    chk("in_full_ri", 64'(net_ri), 64'd0);
    net_di = I5;
    step();
    net_si = 1'b0;
    rd(2'b01, ST_2_FLAG, "in_full_stat");
    rd(2'b00, I3, "in_full_rd1");
    @(negedge clk);
    chk("in_ri_rise", 64'(net_ri), 64'd1);
    step();
    rd(2'b00, I4, "in_full_rd2");
    rd(2'b00, 64'd0, "in_no_5th");

    // outbound VC polarity gating
    net_ro = 1'b1;
    net_polarity = 1'b1;
    wr(2'b10, PC);
    @(negedge clk);
    chk("pol_hold_so", 64'(net_so), 64'd0);
    chk("pol_hold_do", net_do, PC);
    step();
    @(negedge clk);
    chk("pol_hold2_so", 64'(net_so), 64'd0);
    net_polarity = 1'b0;
    #1;
    chk("pol_send_so", 64'(net_so), 64'd1);
    chk("pol_send_do", net_do, PC);
    step();
    @(negedge clk);
    chk("pol_after_so", 64'(net_so), 64'd0);
    chk("pol_after_do", net_do, 64'd0);
    step();
    rd(2'b11, 64'd0, "pol_ostat");

    // outbound full, third write dropped
    net_ro = 1'b0;
    wr(2'b10, P1);
    wr(2'b10, P2);
    wr(2'b10, P3);
    rd(2'b11, ST_2_FLAG, "ofull_stat");
    rd(2'b10, 64'd0, "obuf_rd");
    net_ro = 1'b1;
    @(negedge clk);
    chk("ofull_so1", 64'(net_so), 64'd1);
    chk("ofull_do1", net_do, P1);
    step();
    @(negedge clk);
    chk("ofull_so2", 64'(net_so), 64'd1);
    chk("ofull_do2", net_do, P2);
    step();
    @(negedge clk);
    chk("ofull_so3", 64'(net_so), 64'd0);
    chk("ofull_do3", net_do, 64'd0);
    step();
    net_ro = 1'b0;

    // simultaneous push/pop on each FIFO
    net_si = 1'b1;
    net_di = I1;
    step();
    net_si = 1'b0;
    wr(2'b10, P1);
    net_si = 1'b1;
    net_di = I2;
    rd(2'b00, I1, "sim_in_rd");
    net_si = 1'b0;
    net_ro = 1'b1;
    nicEn = 1'b1;
    nicWrEn = 1'b1;
    addr = 2'b10;
    d_in = P2;
    @(negedge clk);
    chk("sim_so", 64'(net_so), 64'd1);
    chk("sim_do", net_do, P1);
    step();
    nicEn = 1'b0;
    nicWrEn = 1'b0;
    net_ro = 1'b0;
    rd(2'b11, ST_1, "sim_ostat");
    rd(2'b01, ST_1_FLAG, "sim_istat");
    rd(2'b00, I2, "sim_in_order");
    net_ro = 1'b1;
    @(negedge clk);
    chk("sim_out_order", net_do, P2);
    step();
    net_ro = 1'b0;
    rd(2'b11, 64'd0, "sim_ostat_end");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
